// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR control logic.
// Build option: define SAR_SETTLE_EN to add a one-cycle DAC settle state
// ahead of every comparator wait (3 cycles per bit instead of 2).
package sar_pkg;

  localparam int SAR_N_DEFAULT = 8;

`ifdef SAR_SETTLE_EN
  localparam int SAR_CPB = 3;
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, DECIDE} sar_state_t;
`else
  localparam int SAR_CPB = 2;
  typedef enum logic [1:0] {IDLE, WAIT, DECIDE} sar_state_t;
`endif

endpackage

// File: rtl/sar_logic_if.sv
// Conversion handshake and comparator/DAC bus of the SAR controller.
interface sar_logic_if #(parameter int N = 8);
  logic         start;
  logic         cmp_out;
  logic [N-1:0] dac_code;
  logic [N-1:0] result;
  logic         valid;
  logic         busy;

  modport master (output start, cmp_out, input dac_code, result, valid, busy);
  modport slave  (input start, cmp_out, output dac_code, result, valid, busy);
endinterface

// File: rtl/sar_step_timer.sv
// Per-bit cycle counter. Runs while the FSM is out of IDLE and raises
// 'decide' in the last cycle before the decision cycle of each bit.
// Build option: SAR_SETTLE_EN (via sar_pkg::SAR_CPB).
module sar_step_timer
  import sar_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic decide
);

  logic [1:0] cnt;

  // Phase within the current bit; wraps after the decision cycle.
  always_ff @(posedge clk) begin
    if (rst || clr)                   cnt <= '0;
    else if (cnt == 2'(SAR_CPB - 1))  cnt <= '0;
    else                              cnt <= cnt + 2'd1;
  end

  assign decide = (cnt == 2'(SAR_CPB - 2));

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation register control: resolves an N-bit code MSB
// first from a registered comparator decision.
// Build option: SAR_SETTLE_EN inserts a SETTLE cycle before every WAIT.
module sar_logic
  import sar_pkg::*;
#(
  parameter int N = SAR_N_DEFAULT
)(
  input logic        clk,
  input logic        rst,
  sar_logic_if.slave bus
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;

`ifdef SAR_SETTLE_EN
  localparam sar_state_t BIT_ENTRY = SETTLE;
`else
  localparam sar_state_t BIT_ENTRY = WAIT;
`endif

  sar_state_t    state, state_nx;
  logic [N-1:0]  code, code_nx;
  logic [N-1:0]  result_q, result_nx;
  logic [IW-1:0] idx, idx_nx, idx_m1;
  logic          valid_q, valid_nx;
  logic          busy_q, busy_nx;
  logic          decide;

  assign idx_m1 = idx - 1'b1;

  sar_step_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .decide (decide)
  );

  // State and datapath registers; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code     <= '0;
      result_q <= '0;
      idx      <= IW'(N - 1);
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      code     <= code_nx;
      result_q <= result_nx;
      idx      <= idx_nx;
      valid_q  <= valid_nx;
      busy_q   <= busy_nx;
    end
  end

  // Next-state and trial-code update; valid is a single-cycle pulse.
  always_comb begin
    state_nx  = state;
    code_nx   = code;
    result_nx = result_q;
    idx_nx    = idx;
    valid_nx  = 1'b0;
    busy_nx   = busy_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          code_nx        = '0;
          code_nx[N-1]   = 1'b1;
          idx_nx         = IW'(N - 1);
          busy_nx        = 1'b1;
          state_nx       = BIT_ENTRY;
        end
      end
`ifdef SAR_SETTLE_EN
      SETTLE: state_nx = WAIT;
`endif
      WAIT: begin
        if (decide) state_nx = DECIDE;
      end
      DECIDE: begin
        // Tie (cmp_out=0) clears the bit, so the code stays strictly below in_p.
        code_nx[idx] = bus.cmp_out;
        if (idx != '0) begin
          code_nx[idx_m1] = 1'b1;
          idx_nx          = idx_m1;
          state_nx        = BIT_ENTRY;
        end else begin
          result_nx = code_nx;
          valid_nx  = 1'b1;
          busy_nx   = 1'b0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.dac_code = code;
  assign bus.result   = result_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sar_logic.sv
// Bench for sar_logic: ideal 10 V DAC plus registered comparator, with a
// cycle-count reference model of conversion timing and result.
module tb_sar_logic;
  import sar_pkg::*;

  localparam int N = 8;
`ifdef SAR_SETTLE_EN
  localparam int CPB = 3;
`else
  localparam int CPB = 2;
`endif
  localparam int LAT = CPB * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  real  in_p = 0.0;

  sar_logic_if #(.N(N)) bus ();
  sar_logic #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Largest code whose DAC voltage is strictly below v (0 if none).
  function automatic int ref_code(input real v);
    int c = 0;
    for (int k = 0; k < (1 << N); k++)
      if (real'(k) * 10.0 / real'(1 << N) < v) c = k;
    return c;
  endfunction

  // Registered comparator against the ideal DAC output.
  always @(negedge clk)
    bus.cmp_out = (in_p > real'(bus.dac_code) * 10.0 / real'(1 << N));

  // Reference model: an accepted start yields valid LAT edges later.
  logic busy_m = 1'b0, valid_m = 1'b0;
  int   res_m = 0, exp_m = 0, rem = 0;
  always @(posedge clk) begin
    valid_m <= 1'b0;
    if (rst) begin
      busy_m <= 1'b0; res_m <= 0; rem <= 0;
    end else if (!busy_m) begin
      if (bus.start) begin
        busy_m <= 1'b1; rem <= LAT; exp_m <= ref_code(in_p);
      end
    end else if (rem == 1) begin
      busy_m <= 1'b0; valid_m <= 1'b1; res_m <= exp_m; rem <= 0;
    end else begin
      rem <= rem - 1;
    end
  end

  // Per-cycle comparison against the model.
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", bus.valid, valid_m);
      chk("busy", bus.busy, busy_m);
      if (valid_m) chk("result", bus.result, res_m);
      if (!busy_m) begin
        chk("dac_idle", bus.dac_code, res_m);
        chk("result_hold", bus.result, res_m);
      end
    end
  end

  task automatic run_conv(input real v, output int lat, output int bc, output int r);
    @(negedge clk);
    in_p = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    bc  = 0;
    while (!bus.valid && lat < 300) begin
      if (bus.busy) bc++;
      @(negedge clk);
      lat++;
    end
    r = bus.result;
  endtask

  initial begin
    int lat, bc, r, t, last, n;
    real v;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dac", bus.dac_code, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    chk("model_345", ref_code(3.45), 88);
    chk("model_000", ref_code(0.0), 0);
    chk("model_999", ref_code(9.99), 255);
    chk("model_tie", ref_code(5.0), 127);

    run_conv(3.45, lat, bc, r);
    chk("lat_345", lat, LAT);
    chk("busy_cycles", bc, LAT);
    chk("res_345", r, 88);
    run_conv(0.0, lat, bc, r);
    chk("res_zero", r, 0);
    run_conv(9.99, lat, bc, r);
    chk("res_full", r, 255);
    run_conv(5.0, lat, bc, r);
    chk("res_tie", r, 127);

    // Reset in the middle of a conversion.
    @(negedge clk);
    in_p = 3.45;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_dac", bus.dac_code, 0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid) n++;
    end
    chk("midrst_no_valid", n, 0);
    run_conv(3.45, lat, bc, r);
    chk("after_rst_345", r, 88);

    // Start coincident with reset is dropped.
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", bus.busy, 0);
    @(negedge clk);
    chk("rst_start_busy2", bus.busy, 0);

    // Start held high: back-to-back conversions.
    in_p = 6.2;
    bus.start = 1'b1;
    t = 0; last = -1; n = 0;
    while (n < 4 && t < 400) begin
      @(negedge clk);
      t++;
      if (bus.valid) begin
        if (last >= 0) chk("period", t - last, LAT + 1);
        chk("held_res", bus.result, 158);
        last = t;
        n++;
      end
    end
    chk("held_pulses", n, 4);
    bus.start = 1'b0;
    t = 0;
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_busy", bus.busy, 0);

    // Random input voltages with random idle gaps.
    repeat (25) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      v = real'($urandom_range(0, 10000)) / 1000.0;
      run_conv(v, lat, bc, r);
      chk("rnd_lat", lat, LAT);
      chk("rnd_res", r, ref_code(v));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
